// File: rtl/mat_row_mem_arb.sv
// Round-robin arbiter between the row-streaming engines and one dual-port
// row memory. The read and write ports are arbitrated independently.
// Reads come back tagged with their owner after MEM_LATENCY+1 cycles.
// A read of the row being written in the same cycle is held back one cycle,
// so that it returns the new row.
module mat_row_mem_arb #(
  parameter int SIZE        = 4,
  parameter int WIDTH       = 64,
  parameter int NUM_CLIENTS = 2,
  parameter int MEM_LATENCY = 1,
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int RW = SIZE * 2 * WIDTH,
  localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic [NUM_CLIENTS-1:0][AW-1:0]  rd_addr_i,
  input  logic [NUM_CLIENTS-1:0]          rd_addr_valid_i,
  output logic [NUM_CLIENTS-1:0]          rd_addr_ready_o,
  output logic [RW-1:0]                   rd_row_o,
  output logic [AW-1:0]                   rd_row_addr_o,
  output logic [NUM_CLIENTS-1:0]          rd_row_valid_o,
  input  logic [NUM_CLIENTS-1:0][RW-1:0]  wr_row_i,
  input  logic [NUM_CLIENTS-1:0][AW-1:0]  wr_addr_i,
  input  logic [NUM_CLIENTS-1:0]          wr_valid_i,
  output logic [NUM_CLIENTS-1:0]          wr_ready_o,
  output logic                            mem_rd_en_o,
  output logic [AW-1:0]                   mem_rd_addr_o,
  input  logic [RW-1:0]                   mem_rd_data_i,
  output logic                            mem_wr_en_o,
  output logic [AW-1:0]                   mem_wr_addr_o,
  output logic [RW-1:0]                   mem_wr_data_o,
  output logic                            busy_o
);

  logic [CW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] wr_win, rd_win;
  logic          wr_found, rd_found;
  logic          wr_gnt, rd_gnt, rd_hazard;

  // Return tracker: stage 0 is loaded by a read grant, stage MEM_LATENCY-1
  // lines up with valid memory read data.
  logic [MEM_LATENCY-1:0]         trk_vld_q;
  logic [MEM_LATENCY-1:0][CW-1:0] trk_id_q;
  logic [MEM_LATENCY-1:0][AW-1:0] trk_addr_q;

  function automatic logic [CW-1:0] rr_add(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CLIENTS) s -= NUM_CLIENTS;
    return CW'(s);
  endfunction

  // Write winner: first requester at or after wptr
  always_comb begin
    logic [CW-1:0] cand;
    cand     = '0;
    wr_found = 1'b0;
    wr_win   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cand = rr_add(wptr_q, i);
      if (!wr_found && wr_valid_i[cand]) begin
        wr_found = 1'b1;
        wr_win   = cand;
      end
    end
  end

  // Read winner: first requester at or after rptr
  always_comb begin
    logic [CW-1:0] cand;
    cand     = '0;
    rd_found = 1'b0;
    rd_win   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cand = rr_add(rptr_q, i);
      if (!rd_found && rd_addr_valid_i[cand]) begin
        rd_found = 1'b1;
        rd_win   = cand;
      end
    end
  end

  // Grants and memory commands; nothing is issued in reset or in a flush cycle
  always_comb begin
    wr_gnt          = wr_found && rst_ni && !flush_i;
    mem_wr_en_o     = wr_gnt;
    mem_wr_addr_o   = wr_addr_i[wr_win];
    mem_wr_data_o   = wr_row_i[wr_win];
    wr_ready_o      = wr_gnt ? (NUM_CLIENTS'(1) << wr_win) : '0;
    mem_rd_addr_o   = rd_addr_i[rd_win];
    rd_hazard       = mem_wr_en_o && (mem_rd_addr_o == mem_wr_addr_o);
    rd_gnt          = rd_found && !rd_hazard && rst_ni && !flush_i;
    mem_rd_en_o     = rd_gnt;
    rd_addr_ready_o = rd_gnt ? (NUM_CLIENTS'(1) << rd_win) : '0;
  end

  // Round-robin pointers advance past the last granted client
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_gnt) wptr_q <= rr_add(wr_win, 1);
      if (rd_gnt) rptr_q <= rr_add(rd_win, 1);
    end
  end

  // Shift outstanding reads along with the memory pipeline
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trk_vld_q  <= '0;
      trk_id_q   <= '0;
      trk_addr_q <= '0;
    end else begin
      trk_vld_q[0]  <= rd_gnt;
      trk_id_q[0]   <= rd_win;
      trk_addr_q[0] <= mem_rd_addr_o;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        trk_vld_q[i]  <= trk_vld_q[i-1] && !flush_i;
        trk_id_q[i]   <= trk_id_q[i-1];
        trk_addr_q[i] <= trk_addr_q[i-1];
      end
    end
  end

  // Capture the returning row and tag it with its owner for one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_row_valid_o <= '0;
      rd_row_o       <= '0;
      rd_row_addr_o  <= '0;
    end else begin
      rd_row_valid_o <= '0;
      if (!flush_i && trk_vld_q[MEM_LATENCY-1]) begin
        rd_row_valid_o <= NUM_CLIENTS'(1) << trk_id_q[MEM_LATENCY-1];
        rd_row_o       <= mem_rd_data_i;
        rd_row_addr_o  <= trk_addr_q[MEM_LATENCY-1];
      end
    end
  end

  assign busy_o = (|trk_vld_q) || (|rd_row_valid_o);

endmodule

// File: tb/tb_mat_row_mem_arb.sv
// Bench for mat_row_mem_arb: three clients, memory latency 2, small rows.
// A transaction-level model (expected winners, shadow memory, queue of
// pending returns) is compared against the DUT every cycle.
module tb_mat_row_mem_arb;
  localparam int SIZE = 4;
  localparam int WIDTH = 16;
  localparam int N = 3;
  localparam int L = 2;
  localparam int AW = 2;
  localparam int RW = SIZE * 2 * WIDTH;

  logic                 clk, rst_n, flush;
  logic [N-1:0][AW-1:0] raddr, waddr;
  logic [N-1:0]         rvld, wvld;
  logic [N-1:0][RW-1:0] wrow;
  logic [N-1:0]         rd_ready, rd_row_valid, wr_ready;
  logic [RW-1:0]        rd_row, mem_rd_data, mem_wr_data;
  logic [AW-1:0]        rd_row_addr, mem_rd_addr, mem_wr_addr;
  logic                 mem_rd_en, mem_wr_en, busy;

  mat_row_mem_arb #(.SIZE(SIZE), .WIDTH(WIDTH), .NUM_CLIENTS(N), .MEM_LATENCY(L)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .rd_addr_i(raddr), .rd_addr_valid_i(rvld), .rd_addr_ready_o(rd_ready),
    .rd_row_o(rd_row), .rd_row_addr_o(rd_row_addr), .rd_row_valid_o(rd_row_valid),
    .wr_row_i(wrow), .wr_addr_i(waddr), .wr_valid_i(wvld), .wr_ready_o(wr_ready),
    .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data),
    .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
    .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [RW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {(RW/32){w}};
  endfunction

  // Row memory environment: write at the edge, read data L cycles after the command
  logic [RW-1:0] mem [SIZE];
  logic [RW-1:0] rdpipe [L];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= pat(i);
    end else if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
    rdpipe[0] <= mem_rd_en ? mem[mem_rd_addr] : '0;
    for (int i = 1; i < L; i++) rdpipe[i] <= rdpipe[i-1];
  end
  assign mem_rd_data = rdpipe[L-1];

  // Reference model state
  typedef struct {
    int            due;
    int            cl;
    int            addr;
    logic [RW-1:0] data;
  } ret_t;
  ret_t          q[$];
  logic [RW-1:0] ref_mem [SIZE];
  int            wptr_m, rptr_m, cyc;
  int            n_chk, n_fail;
  logic [N-1:0]  snap_rd_ready, snap_wr_ready, snap_valid;
  logic [AW-1:0] snap_row_addr;
  logic [RW-1:0] snap_row;
  logic          snap_busy;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wptr_m = 0;
    rptr_m = 0;
    for (int i = 0; i < SIZE; i++) ref_mem[i] = pat(i);
    snap_rd_ready = '0;
    snap_wr_ready = '0;
  endtask

  // One clock cycle: compare DUT against the model at the falling edge,
  // advance the model, and return just after the next rising edge.
  task automatic tick();
    int ew, er, idx;
    logic [N-1:0] ewr, err, eval;
    ret_t r;
    @(negedge clk);
    ew = -1;
    er = -1;
    for (int i = 0; i < N; i++) begin
      idx = (wptr_m + i) % N;
      if (ew < 0 && wvld[idx]) ew = idx;
      idx = (rptr_m + i) % N;
      if (er < 0 && rvld[idx]) er = idx;
    end
    if (flush) begin
      ew = -1;
      er = -1;
    end
    if (er >= 0 && ew >= 0 && raddr[er] == waddr[ew]) er = -1;
    ewr = '0;
    err = '0;
    if (ew >= 0) ewr[ew] = 1'b1;
    if (er >= 0) err[er] = 1'b1;
    chk("wr_ready", RW'(wr_ready), RW'(ewr));
    chk("mem_wr_en", RW'(mem_wr_en), RW'(ew >= 0));
    if (ew >= 0) begin
      chk("mem_wr_addr", RW'(mem_wr_addr), RW'(waddr[ew]));
      chk("mem_wr_data", mem_wr_data, wrow[ew]);
    end
    chk("rd_ready", RW'(rd_ready), RW'(err));
    chk("mem_rd_en", RW'(mem_rd_en), RW'(er >= 0));
    if (er >= 0) chk("mem_rd_addr", RW'(mem_rd_addr), RW'(raddr[er]));
    chk("busy", RW'(busy), RW'(q.size() != 0));
    eval = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      r = q.pop_front();
      eval[r.cl] = 1'b1;
      chk("rd_row_addr", RW'(rd_row_addr), RW'(r.addr));
      chk("rd_row", rd_row, r.data);
    end
    chk("rd_row_valid", RW'(rd_row_valid), RW'(eval));
    snap_rd_ready = rd_ready;
    snap_wr_ready = wr_ready;
    snap_valid    = rd_row_valid;
    snap_row_addr = rd_row_addr;
    snap_row      = rd_row;
    snap_busy     = busy;
    if (er >= 0) begin
      r.due  = cyc + L + 1;
      r.cl   = er;
      r.addr = int'(raddr[er]);
      r.data = ref_mem[raddr[er]];
      q.push_back(r);
      rptr_m = (er + 1) % N;
    end
    if (ew >= 0) begin
      ref_mem[waddr[ew]] = wrow[ew];
      wptr_m = (ew + 1) % N;
    end
    if (flush) begin
      q.delete();
      wptr_m = 0;
      rptr_m = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Random requests that keep an ungranted request stable or withdraw it
  task automatic rand_drive();
    for (int c = 0; c < N; c++) begin
      if (rvld[c] && !snap_rd_ready[c]) begin
        if ($urandom_range(0, 4) == 0) rvld[c] = 1'b0;
      end else begin
        rvld[c]  = ($urandom_range(0, 9) < 6);
        raddr[c] = AW'($urandom_range(0, SIZE - 1));
      end
      if (wvld[c] && !snap_wr_ready[c]) begin
        if ($urandom_range(0, 4) == 0) wvld[c] = 1'b0;
      end else begin
        wvld[c]  = ($urandom_range(0, 9) < 4);
        waddr[c] = AW'($urandom_range(0, SIZE - 1));
        for (int k = 0; k < RW / 32; k++) wrow[c][k*32 +: 32] = $urandom;
      end
    end
    flush = ($urandom_range(0, 39) == 0);
  endtask

  task automatic idle_inputs();
    rvld  = '0;
    wvld  = '0;
    flush = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    raddr = '0;
    waddr = '0;
    wrow = '0;
    flush = 1'b0;
    rvld = '1;
    wvld = '1;
    rst_n = 1'b0;
    model_reset();

    // Reset state, with every client requesting
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_ready", RW'(rd_ready), '0);
    chk("rst_wr_ready", RW'(wr_ready), '0);
    chk("rst_mem_en", RW'({mem_rd_en, mem_wr_en}), '0);
    chk("rst_valid", RW'(rd_row_valid), '0);
    chk("rst_row", rd_row, '0);
    chk("rst_row_addr", RW'(rd_row_addr), '0);
    chk("rst_busy", RW'(busy), '0);
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single read of addr 2 by client 0, returned L+1 cycles later
    rvld = 3'b001;
    raddr[0] = 2'd2;
    tick();
    chk("single_grant", RW'(snap_rd_ready), RW'(3'b001));
    chk("single_busy0", RW'(snap_busy), RW'(1'b0));
    rvld = '0;
    tick();
    chk("single_busy1", RW'(snap_busy), RW'(1'b1));
    tick();
    tick();
    chk("single_valid", RW'(snap_valid), RW'(3'b001));
    chk("single_addr", RW'(snap_row_addr), RW'(2'd2));
    chk("single_row", snap_row, pat(2));
    tick();
    chk("single_busy_end", RW'(snap_busy), RW'(1'b0));

    // Contention between clients 0 and 1; rptr sits at 1 after the last grant
    rvld = 3'b011;
    raddr[0] = 2'd1;
    raddr[1] = 2'd3;
    tick();
    chk("cont_grant0", RW'(snap_rd_ready), RW'(3'b010));
    tick();
    chk("cont_grant1", RW'(snap_rd_ready), RW'(3'b001));
    repeat (4) tick();
    rvld = '0;
    repeat (4) tick();

    // Read-after-write hazard on addr 1
    wvld = 3'b001;
    waddr[0] = 2'd1;
    wrow[0] = {(RW/32){32'hDEAD_BEEF}};
    rvld = 3'b010;
    raddr[1] = 2'd1;
    tick();
    chk("haz_rd_ready", RW'(snap_rd_ready), RW'(3'b000));
    chk("haz_wr_ready", RW'(snap_wr_ready), RW'(3'b001));
    wvld = '0;
    tick();
    chk("haz_rd_late", RW'(snap_rd_ready), RW'(3'b010));
    rvld = '0;
    repeat (3) tick();
    chk("haz_valid", RW'(snap_valid), RW'(3'b010));
    chk("haz_row", snap_row, {(RW/32){32'hDEAD_BEEF}});

    // Flush drops the in-flight read and resets the read pointer
    rvld = 3'b100;
    raddr[2] = 2'd0;
    tick();
    chk("flush_grant_t", RW'(snap_rd_ready), RW'(3'b100));
    rvld = 3'b010;
    raddr[1] = 2'd2;
    flush = 1'b1;
    tick();
    chk("flush_no_grant", RW'(snap_rd_ready), RW'(3'b000));
    flush = 1'b0;
    rvld = 3'b111;
    raddr[0] = 2'd0;
    raddr[1] = 2'd1;
    raddr[2] = 2'd2;
    tick();
    chk("flush_busy", RW'(snap_busy), RW'(1'b0));
    chk("flush_next", RW'(snap_rd_ready), RW'(3'b001));
    idle_inputs();
    repeat (4) tick();

    // Randomized traffic
    repeat (600) begin
      rand_drive();
      tick();
    end

    // Asynchronous reset with two reads in flight
    idle_inputs();
    repeat (4) tick();
    rvld = 3'b001;
    raddr[0] = 2'd3;
    tick();
    rvld = 3'b010;
    raddr[1] = 2'd0;
    tick();
    rvld = '1;
    wvld = '1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", RW'(rd_row_valid), '0);
    chk("arst_busy", RW'(busy), '0);
    chk("arst_row", rd_row, '0);
    chk("arst_row_addr", RW'(rd_row_addr), '0);
    chk("arst_rd_ready", RW'(rd_ready), '0);
    chk("arst_wr_ready", RW'(wr_ready), '0);
    chk("arst_mem_en", RW'({mem_rd_en, mem_wr_en}), '0);
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
    repeat (6) tick();

    repeat (300) begin
      rand_drive();
      tick();
    end
    idle_inputs();
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
